// File: rtl/count_checker_pkg.sv
// Shared definitions for the counter-sequence checker and its counter source.
// Keeping W here means both ends of the link agree on the count width.
package count_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int CC_W      = 8;
  localparam int CC_LOCK_N = 4;
  localparam int CC_LOSS_N = 2;
  localparam int CC_ERRW   = 16;

endpackage

// File: rtl/count_checker_if.sv
// Sample stream in, lock/error status out. The master side is the stream source
// and status consumer; the checker sits on the slave side.
interface count_checker_if
  import count_checker_pkg::*;
#(
  parameter int W    = CC_W,
  parameter int ERRW = CC_ERRW
);
  logic            in_valid;
  logic [W-1:0]    count;
  logic            clr;
  logic            locked;
  logic            err;
  logic [ERRW-1:0] err_count;
  logic [W-1:0]    expected;

  modport master (
    output in_valid, count, clr,
    input  locked, err, err_count, expected
  );

  modport slave (
    input  in_valid, count, clr,
    output locked, err, err_count, expected
  );
endinterface

// File: rtl/count_checker_sat_counter.sv
// Up-counter that sticks at all-ones; a clear in the same cycle as an increment
// wins so that software sees a clean zero after clearing.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_value
);
  logic [WIDTH-1:0] r_value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_value <= '0;
    else if (i_clr)
      r_value <= '0;
    else if (i_inc && (r_value != '1))
      r_value <= r_value + WIDTH'(1);
  end

  assign o_value = r_value;
endmodule

// File: rtl/count_checker.sv
// Locks onto a +1 counter stream and flags every sample that breaks it.
// Once locked, the expectation freewheels so one corrupted sample costs one error.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int W      = CC_W,
  parameter int LOCK_N = CC_LOCK_N,
  parameter int LOSS_N = CC_LOSS_N,
  parameter int ERRW   = CC_ERRW
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  count_checker_if.slave bus
);
  localparam logic [7:0] LOCK_CNT = 8'(LOCK_N);
  localparam logic [7:0] LOSS_CNT = 8'(LOSS_N);

  state_e          r_state;
  logic [W-1:0]    r_exp;
  logic [7:0]      r_run;
  logic [7:0]      r_miss;
  logic            r_locked;
  logic            r_err;

  logic            w_match;
  logic            w_bad;
  logic [W-1:0]    w_cnt_p1;
  logic [W-1:0]    w_exp_p1;
  logic [7:0]      w_run_p1;
  logic [7:0]      w_miss_p1;
  logic [ERRW-1:0] w_err_count;

  assign w_match   = (bus.count == r_exp);
  assign w_cnt_p1  = bus.count + W'(1);
  assign w_exp_p1  = r_exp + W'(1);
  assign w_run_p1  = r_run + 8'd1;
  assign w_miss_p1 = r_miss + 8'd1;
  // Only mismatches seen while locked are errors; acquisition mismatches just reseed.
  assign w_bad     = bus.in_valid && (r_state == ST_LOCKED) && !w_match;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_SEARCH;
      r_exp    <= '0;
      r_run    <= '0;
      r_miss   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (bus.in_valid) begin
        case (r_state)
          ST_SEARCH: begin
            r_exp   <= w_cnt_p1;
            r_run   <= 8'd1;
            r_state <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            r_exp <= w_cnt_p1;
            if (w_match) begin
              r_run <= w_run_p1;
              if (w_run_p1 == LOCK_CNT) begin
                r_state  <= ST_LOCKED;
                r_miss   <= 8'd0;
                r_locked <= 1'b1;
              end
            end else begin
              r_run <= 8'd1;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_exp  <= w_exp_p1;
              r_miss <= 8'd0;
            end else begin
              r_err  <= 1'b1;
              r_miss <= w_miss_p1;
              if (w_miss_p1 == LOSS_CNT) begin
                // Persistent disagreement: resynchronise on the new sequence.
                r_state  <= ST_ACQUIRE;
                r_exp    <= w_cnt_p1;
                r_run    <= 8'd1;
                r_locked <= 1'b0;
              end else begin
                r_exp <= w_exp_p1;
              end
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(ERRW)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_bad),
    .i_clr   (bus.clr),
    .o_value (w_err_count)
  );

  assign bus.locked    = r_locked;
  assign bus.err       = r_err;
  assign bus.err_count = w_err_count;
  assign bus.expected  = r_exp;
endmodule
